// File: rtl/tdsp_bus_arb_if.sv
// -----------------------------------------------------------------------------
// tdsp_bus_arb_if
// Shared external memory bus arbitration signals of the tdsp subsystem.
//   req      : request vector, req[0] is the core's bus_request
//   grant    : one-hot or all-zero grant vector, grant[0] is the core's bus_grant
//   bus_busy : high while any grant bit is high
//   owner    : index of the current owner (0 when the bus is idle)
//   preempt  : one-cycle pulse when a secondary grant is revoked by timeout
// Modports:
//   master : requester side (drives req, observes the arbiter outputs)
//   slave  : arbiter side (observes req, drives grant and status)
// -----------------------------------------------------------------------------
interface tdsp_bus_arb_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic            bus_busy;
  logic [2:0]      owner;
  logic            preempt;

  modport master (output req, input grant, input bus_busy, input owner, input preempt);
  modport slave  (input req, output grant, output bus_busy, output owner, output preempt);
endinterface

// File: rtl/tdsp_bus_arb.sv
// -----------------------------------------------------------------------------
// tdsp_bus_arb
// Arbiter for the shared external memory bus. Requester 0 (the core) has fixed
// top priority and is never preempted; secondary requesters are served
// round-robin and lose the bus after MAX_HOLD cycles of the core waiting.
// Every release is followed by TURN idle turnaround cycles. All outputs are
// registered.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : tdsp_bus_arb_if.slave (req in; grant, bus_busy, owner, preempt out)
// -----------------------------------------------------------------------------
module tdsp_bus_arb #(
  parameter int NREQ     = 3,  // 2..8, includes the core
  parameter int MAX_HOLD = 8,  // 1..255
  parameter int TURN     = 1   // 0..3
) (
  input  logic         clk,
  input  logic         reset,
  tdsp_bus_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_e;

  // With no turnaround a release returns straight to arbitration.
  localparam state_e AFTER_OWN = (TURN == 0) ? S_IDLE : S_TURN;

  state_e          state_q, state_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;
  logic [1:0]      turn_cnt_q, turn_cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            bus_busy_q, bus_busy_d;
  logic [2:0]      owner_q, owner_d;
  logic            preempt_q, preempt_d;

  logic            win_valid;
  logic [2:0]      winner;
  logic            own_req;
  logic            release_own;
  logic            timeout_own;
  logic [2:0]      rr_next_own;

  // Winner selection: core first, then the first secondary at or above
  // rr_ptr, then wrap around to the secondaries below rr_ptr.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    win_valid = 1'b0;
    winner    = 3'd0;
    if (bus.req[0]) begin
      win_valid = 1'b1;
    end else begin
      for (int i = 1; i < NREQ; i++) begin
        if (!win_valid && bus.req[i] && (i >= int'(rr_ptr_q))) begin
          win_valid = 1'b1;
          winner    = 3'(i);
        end
      end
      for (int i = 1; i < NREQ; i++) begin
        if (!win_valid && bus.req[i] && (i < int'(rr_ptr_q))) begin
          win_valid = 1'b1;
          winner    = 3'(i);
        end
      end
    end
  end

  // Request line of the current owner.
  always_comb begin
    own_req = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == 3'(i)) own_req = bus.req[i];
    end
  end

  assign release_own = !own_req;
  // A release on the timeout edge wins, so the timeout requires own_req.
  assign timeout_own = (owner_q != 3'd0) && bus.req[0] && own_req &&
                       (hold_cnt_q == 8'(MAX_HOLD - 1));
  assign rr_next_own = (owner_q == 3'(NREQ - 1)) ? 3'd1 : owner_q + 3'd1;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= 3'd1;
      hold_cnt_q <= 8'd0;
      turn_cnt_q <= 2'd0;
      grant_q    <= '0;
      bus_busy_q <= 1'b0;
      owner_q    <= 3'd0;
      preempt_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      grant_q    <= grant_d;
      bus_busy_q <= bus_busy_d;
      owner_q    <= owner_d;
      preempt_q  <= preempt_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          state_d    = S_OWN;
          hold_cnt_d = 8'd0;
        end
      end
      S_OWN: begin
        if (release_own || timeout_own) begin
          state_d    = AFTER_OWN;
          turn_cnt_d = 2'd0;
          hold_cnt_d = 8'd0;
          if (owner_q != 3'd0) rr_ptr_d = rr_next_own;
        end else if ((owner_q != 3'd0) && bus.req[0]) begin
          // Only counts while the core waits; timeout fires before overflow.
          hold_cnt_d = hold_cnt_q + 8'd1;
        end else begin
          hold_cnt_d = 8'd0;
        end
      end
      S_TURN: begin
        if (turn_cnt_q == 2'(TURN - 1)) state_d = S_IDLE;
        else                            turn_cnt_d = turn_cnt_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic (values for the registered outputs)
  always_comb begin
    grant_d    = '0;
    bus_busy_d = 1'b0;
    owner_d    = 3'd0;
    preempt_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          for (int i = 0; i < NREQ; i++) begin
            if (winner == 3'(i)) grant_d[i] = 1'b1;
          end
          bus_busy_d = 1'b1;
          owner_d    = winner;
        end
      end
      S_OWN: begin
        if (release_own || timeout_own) begin
          preempt_d = timeout_own;
        end else begin
          grant_d    = grant_q;
          bus_busy_d = 1'b1;
          owner_d    = owner_q;
        end
      end
      default: ;
    endcase
  end

  assign bus.grant    = grant_q;
  assign bus.bus_busy = bus_busy_q;
  assign bus.owner    = owner_q;
  assign bus.preempt  = preempt_q;

endmodule
